product_bcd_converter: RTL and testbench

//   Downstream of the 8x8 signed shift-add multiplier. Captures the 16-bit product {Aval,Bval}
//   on a Start pulse and converts it to a sign flag plus 5 BCD digits.

---
 rtl/product_bcd_converter.sv | 113 +++++++++++
 tb/tb_product_bcd_converter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// Signed/unsigned binary-to-BCD converter for the multiplier product.
// Iterative double-dabble: one input bit per clock, MSB first.
//
// Handshake: Start is sampled only while IDLE; a sampled Start captures Product
// and Signed_Mode. Busy is high while bits are being shifted. Done is a
// one-cycle pulse, and BCD/Neg are valid from that cycle until the next Done.
// Start is ignored outside IDLE, so holding it high does not queue a second run.
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Signed_Mode,
    input  logic [WIDTH-1:0]      Product,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Neg,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [1:0]            state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] shifted;
    logic [CW-1:0]       count;
    logic                neg_s;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE waits for Start, CONV runs WIDTH shifts, DONE lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = CONV;
            CONV:    if (count == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[4*DIGITS-2:0], mag[WIDTH-1]};
    end

    // Datapath: capture on accepted Start, shift during CONV, publish on the last shift.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mag     <= '0;
            scratch <= '0;
            count   <= '0;
            neg_s   <= 1'b0;
            BCD     <= '0;
            Neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        // Two's complement negate; 0x8000 maps to itself, which is
                        // the correct magnitude when read as unsigned.
                        mag     <= (Signed_Mode & Product[WIDTH-1]) ? (~Product + 1'b1) : Product;
                        neg_s   <= Signed_Mode & Product[WIDTH-1];
                        scratch <= '0;
                        count   <= '0;
                    end
                end
                CONV: begin
                    scratch <= shifted;
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        BCD <= shifted;
                        Neg <= neg_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy      = (state == CONV);
    assign Done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed cases plus random
// conversions, checked against a decimal reference built with / and %.
module tb_product_bcd_converter;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed_Mode;
    logic [15:0] Product;
    logic        Busy;
    logic        Done;
    logic        Neg;
    logic [19:0] BCD;
    logic [1:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entries: {neg, bcd}
    logic [20:0] exp_q[$];

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Signed_Mode (Signed_Mode),
        .Product     (Product),
        .Busy        (Busy),
        .Done        (Done),
        .Neg         (Neg),
        .BCD         (BCD),
        .state_dbg   (state_dbg)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude by plain arithmetic, then decimal digits by / and %.
    function automatic logic [20:0] model(input logic sm, input logic [15:0] prod);
        int unsigned v;
        logic [19:0] d;
        logic        n;
        n = sm && prod[15];
        v = n ? (32'd65536 - 32'(prod)) : 32'(prod);
        d = '0;
        for (int i = 0; i < 5; i++) begin
            d[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {n, d};
    endfunction

    // Drive one conversion, starting from an IDLE cycle at a negedge.
    task automatic run_conv(input string tag, input logic sm, input logic [15:0] prod, input logic hold);
        int          cycles;
        int          busy_cnt;
        logic        hold_ok;
        logic [19:0] prev_bcd;
        logic        prev_neg;
        logic [20:0] exp;
        exp_q.push_back(model(sm, prod));
        prev_bcd    = BCD;
        prev_neg    = Neg;
        Signed_Mode = sm;
        Product     = prod;
        Start       = 1'b1;
        @(negedge Clk);
        if (!hold) Start = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        while (!Done && cycles < 40) begin
            if (Busy) busy_cnt++;
            if (BCD !== prev_bcd || Neg !== prev_neg) hold_ok = 1'b0;
            if (cycles == 5) begin
                Product     = 16'($urandom);
                Signed_Mode = ~sm;
            end
            @(negedge Clk);
            cycles++;
        end
        Start = 1'b0;
        exp = exp_q.pop_front();
        check({tag, "_latency"}, cycles, 16);
        check({tag, "_busy_cycles"}, busy_cnt, 16);
        check({tag, "_prev_hold"}, hold_ok, 1);
        check({tag, "_done"}, Done, 1);
        check({tag, "_bcd"}, BCD, exp[19:0]);
        check({tag, "_neg"}, Neg, exp[20]);
        @(negedge Clk);
        check({tag, "_done_pulse"}, Done, 0);
    endtask

    initial begin
        logic no_done;
        Reset       = 1'b1;
        Start       = 1'b0;
        Signed_Mode = 1'b0;
        Product     = '0;
        repeat (2) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_neg", Neg, 0);
        check("rst_bcd", BCD, 0);
        check("rst_state", state_dbg, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed cases
        run_conv("neg21", 1'b1, 16'hFFEB, 1'b0);
        check("neg21_lit_bcd", BCD, 20'h00021);
        run_conv("u65535", 1'b0, 16'hFFFF, 1'b0);
        check("u65535_lit_bcd", BCD, 20'h65535);
        run_conv("s8000", 1'b1, 16'h8000, 1'b0);
        check("s8000_lit_bcd", BCD, 20'h32768);
        check("s8000_lit_neg", Neg, 1);
        run_conv("zero", 1'b1, 16'h0000, 1'b0);
        run_conv("sq127", 1'b1, 16'h3F01, 1'b0);
        check("sq127_lit_bcd", BCD, 20'h16129);

        // Start held through CONV with Product changing mid-run
        run_conv("hold", 1'b0, 16'd12345, 1'b1);
        no_done = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (Done) no_done = 1'b0;
        end
        check("hold_single_done", no_done, 1);

        // Reset during the conversion, after 8 shifts
        Signed_Mode = 1'b0;
        Product     = 16'd54321;
        Start       = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_bcd", BCD, 0);
        check("abort_neg", Neg, 0);
        check("abort_state", state_dbg, 0);
        @(negedge Clk);
        Reset   = 1'b0;
        no_done = 1'b1;
        repeat (25) begin
            @(negedge Clk);
            if (Done) no_done = 1'b0;
        end
        check("abort_no_done", no_done, 1);
        run_conv("after_abort", 1'b1, 16'hFF81, 1'b0);

        // Back-to-back random conversions
        for (int k = 0; k < 30; k++) begin
            run_conv("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
